// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin arbitration of NUM_CONSUMERS LSU load/store ports onto NUM_CHANNELS memory channels.
// Define LSU_ARB_STATS_EN to build the grant / busy-cycle statistics counters.
module lsu_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]              mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_read_address,
  input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_read_data,
  output logic [NUM_CHANNELS-1:0]              mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_write_data,
  input  logic [NUM_CHANNELS-1:0]              mem_write_ready,
  output logic [31:0]                          arb_grants,
  output logic [31:0]                          arb_busy_cycles
);
  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} state_t;

  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] c_raddr, c_waddr;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] c_wdata, c_rdata_q;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  m_rdata, ch_wdata, gnt_wdata;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  ch_raddr, ch_waddr, gnt_addr;
  logic [NUM_CHANNELS-1:0]                 ch_idle, ch_claim, ch_rvalid, ch_wvalid;
  logic [NUM_CHANNELS-1:0]                 ch_rready, ch_wready, ch_rd_done;
  logic [NUM_CHANNELS-1:0]                 gnt, gnt_rd;
  idx_t [NUM_CHANNELS-1:0]                 ch_idx, gnt_idx, gnt_k;
  logic [NUM_CONSUMERS-1:0]                req, claimed, taken;
  idx_t                                    ptr, ptr_nxt, max_k, sc;

  assign c_raddr = consumer_read_address;
  assign c_waddr = consumer_write_address;
  assign c_wdata = consumer_write_data;
  assign m_rdata = mem_read_data;
  assign req     = consumer_read_valid | consumer_write_valid;

  function automatic idx_t scan_idx(input idx_t base, input int k);
    return idx_t'((int'(base) + k) % NUM_CONSUMERS);
  endfunction

  // Claim mask plus per-consumer ready fan-in from whichever channel serves it
  always_comb begin
    claimed              = '0;
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        if (ch_idx[ch] == idx_t'(c)) begin
          if (ch_claim[ch])  claimed[c]              = 1'b1;
          if (ch_rready[ch]) consumer_read_ready[c]  = 1'b1;
          if (ch_wready[ch]) consumer_write_ready[c] = 1'b1;
        end
      end
    end
  end

  // Lower channels pick first; each pick is added to the taken mask so a later
  // channel in the same cycle cannot double-claim a consumer.
  always_comb begin
    taken     = claimed;
    sc        = '0;
    gnt       = '0;
    gnt_rd    = '0;
    gnt_idx   = '0;
    gnt_k     = '0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        sc = scan_idx(ptr, k);
        if (ch_idle[ch] && !gnt[ch] && req[sc] && !taken[sc]) begin
          gnt[ch]       = 1'b1;
          gnt_rd[ch]    = consumer_read_valid[sc];
          gnt_idx[ch]   = sc;
          gnt_k[ch]     = idx_t'(k);
          gnt_addr[ch]  = consumer_read_valid[sc] ? c_raddr[sc] : c_waddr[sc];
          gnt_wdata[ch] = c_wdata[sc];
          taken[sc]     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    max_k = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++)
      if (gnt[ch] && gnt_k[ch] > max_k) max_k = gnt_k[ch];
    ptr_nxt = scan_idx(ptr, int'(max_k) + 1);
  end

  always_ff @(posedge clk) begin
    if (reset)     ptr <= '0;
    else if (|gnt) ptr <= ptr_nxt;
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    state_t               state;
    logic                 claim, rvalid, wvalid, rready, wready;
    idx_t                 idx;
    logic [ADDR_BITS-1:0] raddr, waddr;
    logic [DATA_BITS-1:0] wdata;

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        claim  <= 1'b0;
        idx    <= '0;
        rvalid <= 1'b0;
        wvalid <= 1'b0;
        rready <= 1'b0;
        wready <= 1'b0;
        raddr  <= '0;
        waddr  <= '0;
        wdata  <= '0;
      end else begin
        case (state)
          IDLE: if (gnt[g]) begin
            claim <= 1'b1;
            idx   <= gnt_idx[g];
            if (gnt_rd[g]) begin
              rvalid <= 1'b1;
              raddr  <= gnt_addr[g];
              state  <= READ_WAIT;
            end else begin
              wvalid <= 1'b1;
              waddr  <= gnt_addr[g];
              wdata  <= gnt_wdata[g];
              state  <= WRITE_WAIT;
            end
          end
          READ_WAIT: if (mem_read_ready[g]) begin
            rvalid <= 1'b0;
            rready <= 1'b1;
            state  <= READ_RELAY;
          end
          WRITE_WAIT: if (mem_write_ready[g]) begin
            wvalid <= 1'b0;
            wready <= 1'b1;
            state  <= WRITE_RELAY;
          end
          // Ready is held until the LSU lets go of its request
          READ_RELAY: if (!consumer_read_valid[idx]) begin
            rready <= 1'b0;
            claim  <= 1'b0;
            state  <= IDLE;
          end
          WRITE_RELAY: if (!consumer_write_valid[idx]) begin
            wready <= 1'b0;
            claim  <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign ch_idle[g]    = (state == IDLE);
    assign ch_claim[g]   = claim;
    assign ch_idx[g]     = idx;
    assign ch_rvalid[g]  = rvalid;
    assign ch_wvalid[g]  = wvalid;
    assign ch_rready[g]  = rready;
    assign ch_wready[g]  = wready;
    assign ch_raddr[g]   = raddr;
    assign ch_waddr[g]   = waddr;
    assign ch_wdata[g]   = wdata;
    assign ch_rd_done[g] = (state == READ_WAIT) && mem_read_ready[g];
  end

  // Read data lives per consumer so it holds until that consumer's next read completes
  always_ff @(posedge clk) begin
    if (reset) c_rdata_q <= '0;
    else
      for (int ch = 0; ch < NUM_CHANNELS; ch++)
        if (ch_rd_done[ch]) c_rdata_q[ch_idx[ch]] <= m_rdata[ch];
  end

  assign consumer_read_data = c_rdata_q;
  assign mem_read_valid     = ch_rvalid;
  assign mem_read_address   = ch_raddr;
  assign mem_write_valid    = ch_wvalid;
  assign mem_write_address  = ch_waddr;
  assign mem_write_data     = ch_wdata;

`ifdef LSU_ARB_STATS_EN
  logic [31:0] grants_q, busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grants_q <= '0;
      busy_q   <= '0;
    end else begin
      grants_q <= grants_q + 32'($countones(gnt));
      busy_q   <= busy_q + 32'($countones(~ch_idle));
    end
  end

  assign arb_grants      = grants_q;
  assign arb_busy_cycles = busy_q;
`else
  assign arb_grants      = '0;
  assign arb_busy_cycles = '0;
`endif

endmodule
